// File: rtl/motor_arb.sv
// motor_arb: two-requester arbiter for a single bidirectional motor.
// Grants the motor to one requester at a time (round-robin on contention),
// stops at end-stops, enforces a motor-off dead time after every run and
// latches a fault on run timeout or on both end-stops asserting together.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_up[1:0]          per-requester drive-up request
//   req_dn[1:0]          per-requester drive-down request
//   up_limit, dn_limit   upper / lower end-stop reached
//   fault_clr            single-cycle clear of the FAULT state
//   motor_up, motor_dn   registered drive commands (never both high)
//   grant[1:0]           registered one-hot motor owner, 0 when unowned
//   fault                registered fault flag
//   arb_state[2:0]       registered state: IDLE=0 RUN_UP=1 RUN_DN=2 DEAD=3 FAULT=4
module motor_arb #(
    parameter int unsigned DEAD_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_up,
    input  logic [1:0] req_dn,
    input  logic       up_limit,
    input  logic       dn_limit,
    input  logic       fault_clr,
    output logic       motor_up,
    output logic       motor_dn,
    output logic [1:0] grant,
    output logic       fault,
    output logic [2:0] arb_state
);

    localparam int unsigned RUN_W  = 16;
    localparam int unsigned DEAD_W = 8;

    // Run counter value at which the next increment would reach TIMEOUT_CYCLES-1.
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(TIMEOUT_CYCLES - 2);
    // Dead counter value of the final dead-time cycle.
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN_UP = 3'd1,
        ST_RUN_DN = 3'd2,
        ST_DEAD   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_motor_up;
    logic                r_motor_dn;
    logic [1:0]          r_grant;
    logic                r_fault;
    logic [RUN_W-1:0]    r_run_cnt;
    logic [DEAD_W-1:0]   r_dead_cnt;
    logic                r_rr_ptr;      // requester favoured on contention

    state_t              w_state_nxt;
    logic                w_motor_up_nxt;
    logic                w_motor_dn_nxt;
    logic [1:0]          w_grant_nxt;
    logic                w_fault_nxt;
    logic [RUN_W-1:0]    w_run_cnt_nxt;
    logic [DEAD_W-1:0]   w_dead_cnt_nxt;
    logic                w_rr_ptr_nxt;

    logic [1:0]          w_vld_up;
    logic [1:0]          w_vld_dn;
    logic [1:0]          w_vld;
    logic                w_win;
    logic                w_own_idx;
    logic                w_own_up;
    logic                w_own_dn;
    logic                w_both_lim;
    logic                w_timeout;

    // Request qualification: exactly one direction set and not already at that end-stop.
    always_comb begin
        w_vld_up = req_up & ~req_dn & {2{~up_limit}};
        w_vld_dn = req_dn & ~req_up & {2{~dn_limit}};
        w_vld    = w_vld_up | w_vld_dn;
    end

    // Winner: the sole valid requester, or the round-robin favourite when both are valid.
    always_comb begin
        if (w_vld == 2'b11) begin
            w_win = r_rr_ptr;
        end else begin
            w_win = w_vld[1];
        end
    end

    // Owner's current request; end-stops are handled separately in the FSM.
    always_comb begin
        w_own_idx  = r_grant[1];
        w_own_up   = req_up[w_own_idx] & ~req_dn[w_own_idx];
        w_own_dn   = req_dn[w_own_idx] & ~req_up[w_own_idx];
        w_both_lim = up_limit & dn_limit;
        w_timeout  = (r_run_cnt == RUN_LAST);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_motor_up <= 1'b0;
            r_motor_dn <= 1'b0;
            r_grant    <= 2'b00;
            r_fault    <= 1'b0;
            r_run_cnt  <= '0;
            r_dead_cnt <= '0;
            r_rr_ptr   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_motor_up <= w_motor_up_nxt;
            r_motor_dn <= w_motor_dn_nxt;
            r_grant    <= w_grant_nxt;
            r_fault    <= w_fault_nxt;
            r_run_cnt  <= w_run_cnt_nxt;
            r_dead_cnt <= w_dead_cnt_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_motor_up_nxt = r_motor_up;
        w_motor_dn_nxt = r_motor_dn;
        w_grant_nxt    = r_grant;
        w_run_cnt_nxt  = r_run_cnt;
        w_dead_cnt_nxt = r_dead_cnt;
        w_rr_ptr_nxt   = r_rr_ptr;

        case (r_state)
            ST_IDLE: begin
                w_motor_up_nxt = 1'b0;
                w_motor_dn_nxt = 1'b0;
                w_grant_nxt    = 2'b00;
                if (w_vld != 2'b00) begin
                    w_grant_nxt   = w_win ? 2'b10 : 2'b01;
                    w_run_cnt_nxt = '0;
                    w_rr_ptr_nxt  = ~w_win;
                    if (w_vld_up[w_win]) begin
                        w_state_nxt    = ST_RUN_UP;
                        w_motor_up_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = ST_RUN_DN;
                        w_motor_dn_nxt = 1'b1;
                    end
                end
            end

            // Both limits outrank everything; a normal stop outranks a timeout.
            ST_RUN_UP: begin
                if (w_both_lim) begin
                    w_state_nxt = ST_FAULT;
                end else if (up_limit || !w_own_up) begin
                    w_state_nxt    = ST_DEAD;
                    w_dead_cnt_nxt = '0;
                end else if (w_timeout) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_run_cnt_nxt = r_run_cnt + RUN_W'(1);
                end
            end

            ST_RUN_DN: begin
                if (w_both_lim) begin
                    w_state_nxt = ST_FAULT;
                end else if (dn_limit || !w_own_dn) begin
                    w_state_nxt    = ST_DEAD;
                    w_dead_cnt_nxt = '0;
                end else if (w_timeout) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_run_cnt_nxt = r_run_cnt + RUN_W'(1);
                end
            end

            // Requests are ignored here, not queued.
            ST_DEAD: begin
                if (r_dead_cnt == DEAD_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_dead_cnt_nxt = r_dead_cnt + DEAD_W'(1);
                end
            end

            ST_FAULT: begin
                if (fault_clr) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_FAULT;
            end
        endcase

        // Motor is released on every entry into (and stay in) DEAD or FAULT.
        if (w_state_nxt == ST_DEAD || w_state_nxt == ST_FAULT) begin
            w_motor_up_nxt = 1'b0;
            w_motor_dn_nxt = 1'b0;
            w_grant_nxt    = 2'b00;
        end

        w_fault_nxt = (w_state_nxt == ST_FAULT);
    end

    assign motor_up  = r_motor_up;
    assign motor_dn  = r_motor_dn;
    assign grant     = r_grant;
    assign fault     = r_fault;
    assign arb_state = r_state;

endmodule

// File: tb/tb_motor_arb.sv
// Directed bench for motor_arb with DEAD_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_motor_arb;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_up;
    logic [1:0] req_dn;
    logic       up_limit;
    logic       dn_limit;
    logic       fault_clr;
    logic       motor_up;
    logic       motor_dn;
    logic [1:0] grant;
    logic       fault;
    logic [2:0] arb_state;

    int n_vec = 0;
    int n_err = 0;

    motor_arb #(
        .DEAD_CYCLES   (4),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_up   (req_up),
        .req_dn   (req_dn),
        .up_limit (up_limit),
        .dn_limit (dn_limit),
        .fault_clr(fault_clr),
        .motor_up (motor_up),
        .motor_dn (motor_dn),
        .grant    (grant),
        .fault    (fault),
        .arb_state(arb_state)
    );

    // Observed word: {arb_state, grant, motor_up, motor_dn, fault}
    logic [7:0] obs;
    assign obs = {arb_state, grant, motor_up, motor_dn, fault};

    localparam logic [7:0] O_IDLE  = {3'd0, 2'b00, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] O_UP0   = {3'd1, 2'b01, 1'b1, 1'b0, 1'b0};
    localparam logic [7:0] O_DN0   = {3'd2, 2'b01, 1'b0, 1'b1, 1'b0};
    localparam logic [7:0] O_DN1   = {3'd2, 2'b10, 1'b0, 1'b1, 1'b0};
    localparam logic [7:0] O_DEAD  = {3'd3, 2'b00, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] O_FAULT = {3'd4, 2'b00, 1'b0, 1'b0, 1'b1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req_up    = 2'b00;
        req_dn    = 2'b00;
        up_limit  = 1'b0;
        dn_limit  = 1'b0;
        fault_clr = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 1'b0;
        #3;
        if (obs !== O_IDLE) begin n_err++; $display("FAIL reset_async: got %b want %b", obs, O_IDLE); end
        n_vec++;
        tick();
        if (obs !== O_IDLE) begin n_err++; $display("FAIL reset_hold: got %b want %b", obs, O_IDLE); end
        n_vec++;
        rst_n = 1'b1;
        tick();
        if (obs !== O_IDLE) begin n_err++; $display("FAIL reset_idle: got %b want %b", obs, O_IDLE); end
        n_vec++;
    endtask

    task automatic test_single_up;
        req_up = 2'b01;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (obs !== O_UP0) begin n_err++; $display("FAIL su_run%0d: got %b want %b", k, obs, O_UP0); end
            n_vec++;
        end
        up_limit = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (obs !== O_DEAD) begin n_err++; $display("FAIL su_dead%0d: got %b want %b", k, obs, O_DEAD); end
            n_vec++;
        end
        tick();
        if (obs !== O_IDLE) begin n_err++; $display("FAIL su_idle: got %b want %b", obs, O_IDLE); end
        n_vec++;
        clear_inputs();
        tick();
    endtask

    task automatic test_round_robin;
        do_reset();
        req_up = 2'b01;
        req_dn = 2'b10;
        tick();
        if (obs !== O_UP0) begin n_err++; $display("FAIL rr_first: got %b want %b", obs, O_UP0); end
        n_vec++;
        clear_inputs();
        tick();
        if (obs !== O_DEAD) begin n_err++; $display("FAIL rr_dead: got %b want %b", obs, O_DEAD); end
        n_vec++;
        repeat (4) tick();
        if (obs !== O_IDLE) begin n_err++; $display("FAIL rr_idle: got %b want %b", obs, O_IDLE); end
        n_vec++;
        req_up = 2'b01;
        req_dn = 2'b10;
        tick();
        if (obs !== O_DN1) begin n_err++; $display("FAIL rr_second: got %b want %b", obs, O_DN1); end
        n_vec++;
        clear_inputs();
        repeat (5) tick();
    endtask

    task automatic test_timeout;
        req_dn = 2'b01;
        for (int k = 0; k < 19; k++) begin
            tick();
            if (obs !== O_DN0) begin n_err++; $display("FAIL to_run%0d: got %b want %b", k, obs, O_DN0); end
            n_vec++;
        end
        tick();
        if (obs !== O_FAULT) begin n_err++; $display("FAIL to_fault: got %b want %b", obs, O_FAULT); end
        n_vec++;
        tick();
        if (obs !== O_FAULT) begin n_err++; $display("FAIL to_hold: got %b want %b", obs, O_FAULT); end
        n_vec++;
        req_dn    = 2'b00;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        if (obs !== O_IDLE) begin n_err++; $display("FAIL to_clear: got %b want %b", obs, O_IDLE); end
        n_vec++;
    endtask

    task automatic test_reversal;
        req_up = 2'b01;
        tick();
        if (obs !== O_UP0) begin n_err++; $display("FAIL rev_up: got %b want %b", obs, O_UP0); end
        n_vec++;
        req_up = 2'b00;
        req_dn = 2'b01;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (obs !== O_DEAD) begin n_err++; $display("FAIL rev_dead%0d: got %b want %b", k, obs, O_DEAD); end
            n_vec++;
        end
        tick();
        if (obs !== O_IDLE) begin n_err++; $display("FAIL rev_idle: got %b want %b", obs, O_IDLE); end
        n_vec++;
        tick();
        if (obs !== O_DN0) begin n_err++; $display("FAIL rev_dn: got %b want %b", obs, O_DN0); end
        n_vec++;
        clear_inputs();
        repeat (5) tick();
    endtask

    task automatic test_double_limit;
        req_dn = 2'b01;
        tick();
        if (obs !== O_DN0) begin n_err++; $display("FAIL dl_run: got %b want %b", obs, O_DN0); end
        n_vec++;
        up_limit = 1'b1;
        dn_limit = 1'b1;
        tick();
        if (obs !== O_FAULT) begin n_err++; $display("FAIL dl_fault: got %b want %b", obs, O_FAULT); end
        n_vec++;
        clear_inputs();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        if (obs !== O_IDLE) begin n_err++; $display("FAIL dl_clear: got %b want %b", obs, O_IDLE); end
        n_vec++;
    endtask

    task automatic test_limit_timeout;
        req_up = 2'b01;
        tick();
        if (obs !== O_UP0) begin n_err++; $display("FAIL lt_run: got %b want %b", obs, O_UP0); end
        n_vec++;
        repeat (18) tick();
        if (obs !== O_UP0) begin n_err++; $display("FAIL lt_run18: got %b want %b", obs, O_UP0); end
        n_vec++;
        up_limit = 1'b1;
        tick();
        if (obs !== O_DEAD) begin n_err++; $display("FAIL lt_dead: got %b want %b", obs, O_DEAD); end
        n_vec++;
        clear_inputs();
        repeat (4) tick();
        if (obs !== O_IDLE) begin n_err++; $display("FAIL lt_idle: got %b want %b", obs, O_IDLE); end
        n_vec++;
    endtask

    task automatic test_invalid;
        req_up = 2'b01;
        req_dn = 2'b01;
        tick();
        if (obs !== O_IDLE) begin n_err++; $display("FAIL inv_both: got %b want %b", obs, O_IDLE); end
        n_vec++;
        req_dn   = 2'b00;
        up_limit = 1'b1;
        tick();
        if (obs !== O_IDLE) begin n_err++; $display("FAIL inv_limit: got %b want %b", obs, O_IDLE); end
        n_vec++;
        req_up = 2'b00;
        req_dn = 2'b10;
        tick();
        if (obs !== O_DN1) begin n_err++; $display("FAIL inv_dn1: got %b want %b", obs, O_DN1); end
        n_vec++;
        clear_inputs();
        repeat (5) tick();
    endtask

    task automatic test_reset_midrun;
        req_up = 2'b01;
        tick();
        if (obs !== O_UP0) begin n_err++; $display("FAIL mr_run: got %b want %b", obs, O_UP0); end
        n_vec++;
        #2;
        rst_n = 1'b0;
        #1;
        if (obs !== O_IDLE) begin n_err++; $display("FAIL mr_async: got %b want %b", obs, O_IDLE); end
        n_vec++;
        #2;
        rst_n = 1'b1;
        tick();
        if (obs !== O_UP0) begin n_err++; $display("FAIL mr_rearm: got %b want %b", obs, O_UP0); end
        n_vec++;
        clear_inputs();
        repeat (5) tick();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_up();
        test_round_robin();
        test_timeout();
        test_reversal();
        test_double_limit();
        test_limit_timeout();
        test_invalid();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/motor_arb.md
MOTOR_ARB -- requirements
Module: motor_arb

Interface
REQ-001 Parameter DEAD_CYCLES, default 4: motor-off cycles enforced after every run, range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: maximum run length in cycles before fault, range 2..65535.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_up  input  2  per-requester request to drive up; bit i belongs to requester i.
REQ-006 req_dn  input  2  per-requester request to drive down.
REQ-007 up_limit  input  1  upper end-stop reached.
REQ-008 dn_limit  input  1  lower end-stop reached.
REQ-009 fault_clr  input  1  single-cycle clear of the FAULT state.
REQ-010 motor_up  output  1  registered drive-up command.
REQ-011 motor_dn  output  1  registered drive-down command.
REQ-012 grant  output  2  registered one-hot owner of the motor; 0 when unowned.
REQ-013 fault  output  1  registered fault flag.
REQ-014 arb_state  output  3  registered FSM state: IDLE=0, RUN_UP=1, RUN_DN=2, DEAD=3, FAULT=4.

Function
REQ-015 Requester i is valid when exactly one of req_up[i] and req_dn[i] is 1; both set or both clear = no request.
REQ-016 A valid up request with up_limit=1, or a valid down request with dn_limit=1, is treated as no request.
REQ-017 In IDLE with one valid requester, that requester wins; with two, the requester not granted most recently wins (round-robin, pointer favours requester 0 after reset).
REQ-018 IDLE with a winner: next edge sets grant to the winner, motor_up or motor_dn per its direction, state RUN_UP/RUN_DN, run counter cleared to 0, round-robin pointer updated.
REQ-019 Latency: request sampled at edge N -> motor output high after edge N; the same edge changes state.
REQ-020 RUN_UP: run counter increments every cycle; exit to DEAD when up_limit=1 or the owner's request is no longer a valid up request.
REQ-021 RUN_DN: same as REQ-020 with dn_limit and valid down request.
REQ-022 RUN_x to FAULT when the run counter reaches TIMEOUT_CYCLES-1 without a DEAD exit condition, or when up_limit and dn_limit are both 1.
REQ-023 Simultaneous limit and timeout: limit wins, DEAD entered; both limits at once: FAULT wins.
REQ-024 Entering DEAD or FAULT: motor_up, motor_dn and grant cleared on that edge.
REQ-025 DEAD: motors off for exactly DEAD_CYCLES cycles, then IDLE; requests during DEAD are ignored, not queued.
REQ-026 A direction reversal always passes through DEAD; motor_up and motor_dn never both 1 and never switch directly from one to the other.
REQ-027 FAULT: fault=1, motors off, grant=0; fault_clr=1 -> IDLE with fault=0 on the next edge; all other inputs ignored.
REQ-028 Unused state encodings go to FAULT.

Reset
REQ-029 rst_n low: arb_state=IDLE, motor_up=0, motor_dn=0, grant=0, fault=0, counters 0, round-robin pointer favouring requester 0, all immediately and asynchronously.
REQ-030 Reset asserted mid-run forces the motor off at once; after release, the block re-arbitrates from IDLE with no dead time owed.

Verification (DEAD_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-031 req_up=01 from IDLE, up_limit rises 5 cycles later -> grant=01, motor_up=1 for 5 cycles, then 4 cycles DEAD, then arb_state=0.
REQ-032 req_up=01 and req_dn=10 together after reset -> requester 0 wins (up); repeat after DEAD -> requester 1 wins (down).
REQ-033 req_dn=01 held, dn_limit never asserts -> motor_dn high 19 cycles, then fault=1, arb_state=4; fault_clr pulse -> arb_state=0, fault=0.
REQ-034 RUN_UP, owner switches to req_dn=01 -> DEAD 4 cycles with both motors 0, then RUN_DN; motor_up and motor_dn never both 1.
REQ-035 Both limits high during RUN_DN -> FAULT next edge; up_limit and 19th-cycle timeout coincide in RUN_UP -> DEAD, fault=0.
REQ-036 rst_n low during RUN_UP -> motor_up=0 asynchronously; req_up=01 after release -> motor_up=1 one edge later.
